// File: rtl/cache_fifo_pkg.sv
// Shared definitions for the cache-line async FIFO and its read-side consumers.
package cache_fifo_pkg;

  // Default geometry of one FIFO entry and of one delivered word.
  localparam int CASH_STR_WIDTH_DEF = 64;
  localparam int WORD_WIDTH_DEF     = 16;

  // State encoding of the line unpacker.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] POP  = 2'd1;
  localparam logic [1:0] CAPT = 2'd2;
  localparam logic [1:0] SEND = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_POP  = POP,
    ST_CAPT = CAPT,
    ST_SEND = SEND
  } unpack_state_t;

  // Width of a word offset; never narrower than one bit.
  function automatic int ofs_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/fifo_line_unpacker.sv
// Pops one cache string from the async FIFO and hands it out word by word,
// lowest word first, over a valid/ready handshake. Counts finished lines and
// lets a flush abandon a partially delivered line.
module fifo_line_unpacker
  import cache_fifo_pkg::*;
#(
  parameter int CASH_STR_WIDTH = CASH_STR_WIDTH_DEF,
  parameter int WORD_WIDTH     = WORD_WIDTH_DEF,
  parameter int WORDS          = CASH_STR_WIDTH / WORD_WIDTH,
  parameter int OFS_WIDTH      = ofs_width(WORDS)
) (
  input  logic                      rd_clk,
  input  logic                      not_reset,
  input  logic                      fifo_empty,
  input  logic [CASH_STR_WIDTH-1:0] fifo_dout,
  output logic                      fifo_read,
  input  logic                      flush,
  output logic [WORD_WIDTH-1:0]     word_data,
  output logic [OFS_WIDTH-1:0]      word_ofs,
  output logic                      word_valid,
  output logic                      word_last,
  input  logic                      word_ready,
  output logic                      busy,
  output logic [7:0]                lines_done
);

  localparam logic [OFS_WIDTH-1:0] LAST_OFS = OFS_WIDTH'(WORDS - 1);

  unpack_state_t             state_reg;
  logic [CASH_STR_WIDTH-1:0] line_reg;
  logic [OFS_WIDTH-1:0]      word_ofs_reg;
  logic [7:0]                lines_done_reg;
  logic                      fifo_read_reg;
  logic                      word_valid_reg;
  logic                      word_last_reg;
  logic                      busy_reg;

  logic [OFS_WIDTH-1:0]      ofs_inc;
  logic [WORD_WIDTH-1:0]     word_arr [WORDS];

  assign ofs_inc = word_ofs_reg + OFS_WIDTH'(1);

  // Slice the held line into words; the offset register picks one.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    assign word_arr[gi] = line_reg[gi*WORD_WIDTH +: WORD_WIDTH];
  end

  assign word_data  = word_arr[word_ofs_reg];
  assign word_ofs   = word_ofs_reg;
  assign word_valid = word_valid_reg;
  assign word_last  = word_last_reg;
  assign fifo_read  = fifo_read_reg;
  assign busy       = busy_reg;
  assign lines_done = lines_done_reg;

  // Line fetch / word delivery FSM with all handshake outputs registered.
  always_ff @(posedge rd_clk or negedge not_reset) begin
    if (!not_reset) begin
      state_reg      <= ST_IDLE;
      line_reg       <= '0;
      word_ofs_reg   <= '0;
      lines_done_reg <= '0;
      fifo_read_reg  <= 1'b0;
      word_valid_reg <= 1'b0;
      word_last_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // Flush is meaningless here; only FIFO occupancy matters.
          if (!fifo_empty) begin
            state_reg     <= ST_POP;
            fifo_read_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        ST_POP: begin
          // The pop is committed this cycle whether or not we flush.
          fifo_read_reg <= 1'b0;
          if (flush) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          if (flush) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            state_reg      <= ST_SEND;
            line_reg       <= fifo_dout;
            word_valid_reg <= 1'b1;
            word_last_reg  <= (WORDS == 1);
          end
        end
        ST_SEND: begin
          if (word_ready) begin
            if (word_last_reg) begin
              state_reg      <= ST_IDLE;
              word_ofs_reg   <= '0;
              lines_done_reg <= lines_done_reg + 8'd1;
              word_valid_reg <= 1'b0;
              word_last_reg  <= 1'b0;
              busy_reg       <= 1'b0;
            end else begin
              word_ofs_reg  <= ofs_inc;
              word_last_reg <= (ofs_inc == LAST_OFS);
            end
          end
          // A word handshaken together with flush still counts as transferred.
          if (flush) begin
            state_reg      <= ST_IDLE;
            word_ofs_reg   <= '0;
            word_valid_reg <= 1'b0;
            word_last_reg  <= 1'b0;
            busy_reg       <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_line_unpacker.sv
// Directed bench for fifo_line_unpacker: a per-cycle vector table plus
// hand-written back-to-back, reset and wrap sequences, against a FIFO model.
module tb_fifo_line_unpacker;
  import cache_fifo_pkg::*;

  localparam int CW = 64;
  localparam int WW = 16;
  localparam int OW = 2;
  localparam int NV = 50;

  logic          rd_clk = 1'b0;
  logic          not_reset = 1'b0;
  logic          fifo_empty;
  logic [CW-1:0] fifo_dout;
  logic          fifo_read;
  logic          flush = 1'b0;
  logic [WW-1:0] word_data;
  logic [OW-1:0] word_ofs;
  logic          word_valid;
  logic          word_last;
  logic          word_ready = 1'b0;
  logic          busy;
  logic [7:0]    lines_done;

  fifo_line_unpacker #(
    .CASH_STR_WIDTH(CW),
    .WORD_WIDTH    (WW),
    .WORDS         (4),
    .OFS_WIDTH     (OW)
  ) dut (
    .rd_clk    (rd_clk),
    .not_reset (not_reset),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_read (fifo_read),
    .flush     (flush),
    .word_data (word_data),
    .word_ofs  (word_ofs),
    .word_valid(word_valid),
    .word_last (word_last),
    .word_ready(word_ready),
    .busy      (busy),
    .lines_done(lines_done)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model with registered read data.
  logic [CW-1:0] mem [1024];
  logic [9:0]    wp = '0;
  logic [9:0]    rp = '0;
  logic          push_en = 1'b0;
  logic [CW-1:0] push_data = '0;

  assign fifo_empty = (wp == rp);

  always @(posedge rd_clk) begin
    if (push_en) begin
      mem[wp] <= push_data;
      wp      <= wp + 10'd1;
    end
    if (fifo_read) begin
      fifo_dout <= mem[rp];
      rp        <= rp + 10'd1;
    end
  end

  // Transfer log: accepted words and the cycles of FIFO pops.
  int          cycle = 0;
  logic [15:0] hs_q[$];
  int          rd_q[$];

  always @(posedge rd_clk) cycle <= cycle + 1;

  always @(negedge rd_clk) begin
    if (word_valid && word_ready) hs_q.push_back(word_data);
    if (fifo_read) rd_q.push_back(cycle);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        push;
    logic [63:0] pdata;
    logic        rdy;
    logic        fl;
    logic        e_read;
    logic        e_valid;
    logic [15:0] e_data;
    logic [1:0]  e_ofs;
    logic        e_last;
    logic        e_busy;
    logic [7:0]  e_ld;
  } vec_t;

  function automatic vec_t mk(input logic push, input logic [63:0] pd, input logic rdy,
                              input logic fl, input logic rd, input logic val,
                              input logic [15:0] d, input logic [1:0] o, input logic last,
                              input logic bsy, input logic [7:0] ld);
    vec_t v;
    v.push = push; v.pdata = pd; v.rdy = rdy; v.fl = fl;
    v.e_read = rd; v.e_valid = val; v.e_data = d; v.e_ofs = o;
    v.e_last = last; v.e_busy = bsy; v.e_ld = ld;
    return v;
  endfunction

  function automatic logic [63:0] b2b_line(input int i);
    logic [63:0] l;
    for (int j = 0; j < 4; j++) l[j*16 +: 16] = {8'hB0 + 8'(i), 8'(j)};
    return l;
  endfunction

  vec_t        tbl [NV];
  logic [79:0] act;
  logic [79:0] exp;

  initial begin
    logic [63:0] l1, la, lb, lc, ld, le;
    int   h0, r0, cnt;
    logic [7:0] ld0;

    l1 = 64'h1111_2222_3333_4444;
    la = 64'hAAAA_BBBB_CCCC_DDDD;
    lb = 64'h0123_4567_89AB_CDEF;
    lc = 64'h5555_6666_7777_8888;
    ld = 64'hDEAD_BEEF_CAFE_F00D;
    le = 64'h0004_0003_0002_0001;

    //          push pdata rdy fl | rd val data     ofs last busy ld
    // basic unpack
    tbl[0]  = mk(1, l1, 1, 0, 0, 0, 16'h0,    0, 0, 0, 0);
    tbl[1]  = mk(0, 0,  1, 0, 0, 0, 16'h0,    0, 0, 0, 0);
    tbl[2]  = mk(0, 0,  1, 0, 1, 0, 16'h0,    0, 0, 1, 0);
    tbl[3]  = mk(0, 0,  1, 0, 0, 0, 16'h0,    0, 0, 1, 0);
    tbl[4]  = mk(0, 0,  1, 0, 0, 1, 16'h4444, 0, 0, 1, 0);
    tbl[5]  = mk(0, 0,  1, 0, 0, 1, 16'h3333, 1, 0, 1, 0);
    tbl[6]  = mk(0, 0,  1, 0, 0, 1, 16'h2222, 2, 0, 1, 0);
    tbl[7]  = mk(0, 0,  1, 0, 0, 1, 16'h1111, 3, 1, 1, 0);
    // backpressure at ofs 1 for 3 cycles
    tbl[8]  = mk(1, l1, 1, 0, 0, 0, 16'h0,    0, 0, 0, 1);
    tbl[9]  = mk(0, 0,  1, 0, 0, 0, 16'h0,    0, 0, 0, 1);
    tbl[10] = mk(0, 0,  1, 0, 1, 0, 16'h0,    0, 0, 1, 1);
    tbl[11] = mk(0, 0,  1, 0, 0, 0, 16'h0,    0, 0, 1, 1);
    tbl[12] = mk(0, 0,  1, 0, 0, 1, 16'h4444, 0, 0, 1, 1);
    tbl[13] = mk(0, 0,  0, 0, 0, 1, 16'h3333, 1, 0, 1, 1);
    tbl[14] = mk(0, 0,  0, 0, 0, 1, 16'h3333, 1, 0, 1, 1);
    tbl[15] = mk(0, 0,  0, 0, 0, 1, 16'h3333, 1, 0, 1, 1);
    tbl[16] = mk(0, 0,  1, 0, 0, 1, 16'h3333, 1, 0, 1, 1);
    tbl[17] = mk(0, 0,  1, 0, 0, 1, 16'h2222, 2, 0, 1, 1);
    tbl[18] = mk(0, 0,  1, 0, 0, 1, 16'h1111, 3, 1, 1, 1);
    // flush at ofs 2 without handshake
    tbl[19] = mk(1, la, 1, 0, 0, 0, 16'h0,    0, 0, 0, 2);
    tbl[20] = mk(0, 0,  1, 0, 0, 0, 16'h0,    0, 0, 0, 2);
    tbl[21] = mk(0, 0,  1, 0, 1, 0, 16'h0,    0, 0, 1, 2);
    tbl[22] = mk(0, 0,  1, 0, 0, 0, 16'h0,    0, 0, 1, 2);
    tbl[23] = mk(0, 0,  1, 0, 0, 1, 16'hDDDD, 0, 0, 1, 2);
    tbl[24] = mk(0, 0,  1, 0, 0, 1, 16'hCCCC, 1, 0, 1, 2);
    tbl[25] = mk(0, 0,  0, 1, 0, 1, 16'hBBBB, 2, 0, 1, 2);
    // next line from ofs 0; flush in IDLE ignored; flush with last handshake
    tbl[26] = mk(1, lb, 1, 0, 0, 0, 16'h0,    0, 0, 0, 2);
    tbl[27] = mk(0, 0,  1, 1, 0, 0, 16'h0,    0, 0, 0, 2);
    tbl[28] = mk(0, 0,  1, 0, 1, 0, 16'h0,    0, 0, 1, 2);
    tbl[29] = mk(0, 0,  1, 0, 0, 0, 16'h0,    0, 0, 1, 2);
    tbl[30] = mk(0, 0,  1, 0, 0, 1, 16'hCDEF, 0, 0, 1, 2);
    tbl[31] = mk(0, 0,  1, 0, 0, 1, 16'h89AB, 1, 0, 1, 2);
    tbl[32] = mk(0, 0,  1, 0, 0, 1, 16'h4567, 2, 0, 1, 2);
    tbl[33] = mk(0, 0,  1, 1, 0, 1, 16'h0123, 3, 1, 1, 2);
    // flush in POP
    tbl[34] = mk(1, lc, 1, 0, 0, 0, 16'h0,    0, 0, 0, 3);
    tbl[35] = mk(0, 0,  1, 0, 0, 0, 16'h0,    0, 0, 0, 3);
    tbl[36] = mk(0, 0,  1, 1, 1, 0, 16'h0,    0, 0, 1, 3);
    // flush in CAPT
    tbl[37] = mk(1, ld, 1, 0, 0, 0, 16'h0,    0, 0, 0, 3);
    tbl[38] = mk(0, 0,  1, 0, 0, 0, 16'h0,    0, 0, 0, 3);
    tbl[39] = mk(0, 0,  1, 0, 1, 0, 16'h0,    0, 0, 1, 3);
    tbl[40] = mk(0, 0,  1, 1, 0, 0, 16'h0,    0, 0, 1, 3);
    // clean line after the flushes
    tbl[41] = mk(1, le, 1, 0, 0, 0, 16'h0,    0, 0, 0, 3);
    tbl[42] = mk(0, 0,  1, 0, 0, 0, 16'h0,    0, 0, 0, 3);
    tbl[43] = mk(0, 0,  1, 0, 1, 0, 16'h0,    0, 0, 1, 3);
    tbl[44] = mk(0, 0,  1, 0, 0, 0, 16'h0,    0, 0, 1, 3);
    tbl[45] = mk(0, 0,  1, 0, 0, 1, 16'h0001, 0, 0, 1, 3);
    tbl[46] = mk(0, 0,  1, 0, 0, 1, 16'h0002, 1, 0, 1, 3);
    tbl[47] = mk(0, 0,  1, 0, 0, 1, 16'h0003, 2, 0, 1, 3);
    tbl[48] = mk(0, 0,  1, 0, 0, 1, 16'h0004, 3, 1, 1, 3);
    tbl[49] = mk(0, 0,  1, 0, 0, 0, 16'h0,    0, 0, 0, 4);

    // Power-on reset state.
    @(negedge rd_clk);
    check("reset_state", 80'({fifo_read, word_valid, word_last, busy, word_ofs, lines_done, word_data}), 80'd0);
    @(posedge rd_clk); #1;
    not_reset = 1'b1;

    // Vector table, one cycle per entry.
    for (int i = 0; i < NV; i++) begin
      push_en    = tbl[i].push;
      push_data  = tbl[i].pdata;
      word_ready = tbl[i].rdy;
      flush      = tbl[i].fl;
      @(negedge rd_clk);
      act = 80'({fifo_read, word_valid, word_last, busy, word_ofs, lines_done,
                 (tbl[i].e_valid ? word_data : 16'h0)});
      exp = 80'({tbl[i].e_read, tbl[i].e_valid, tbl[i].e_last, tbl[i].e_busy, tbl[i].e_ofs,
                 tbl[i].e_ld, (tbl[i].e_valid ? tbl[i].e_data : 16'h0)});
      $display("vec %0d: rd=%b valid=%b data=%h ofs=%0d last=%b busy=%b lines=%0d",
               i, fifo_read, word_valid, word_data, word_ofs, word_last, busy, lines_done);
      check($sformatf("vec%0d", i), act, exp);
      @(posedge rd_clk); #1;
    end
    push_en = 1'b0;
    flush   = 1'b0;

    // Back-to-back: three lines queued at once.
    h0  = hs_q.size();
    r0  = rd_q.size();
    ld0 = lines_done;
    word_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_en   = 1'b1;
      push_data = b2b_line(i);
      @(posedge rd_clk); #1;
    end
    push_en = 1'b0;
    for (int c = 0; c < 80 && lines_done != 8'(ld0 + 8'd3); c++) begin
      @(posedge rd_clk); #1;
    end
    @(posedge rd_clk); #1;
    $display("b2b: reads=%0d words=%0d lines=%0d", rd_q.size() - r0, hs_q.size() - h0, lines_done);
    check("b2b_lines", 80'(lines_done), 80'(8'(ld0 + 8'd3)));
    check("b2b_reads", 80'(rd_q.size() - r0), 80'd3);
    if (rd_q.size() - r0 == 3) begin
      for (int k = 1; k < 3; k++)
        check($sformatf("b2b_gap%0d", k), 80'(rd_q[r0+k] - rd_q[r0+k-1]), 80'd7);
    end
    check("b2b_words", 80'(hs_q.size() - h0), 80'd12);
    cnt = (hs_q.size() - h0 < 12) ? hs_q.size() - h0 : 12;
    for (int w = 0; w < cnt; w++)
      check($sformatf("b2b_word%0d", w), 80'(hs_q[h0+w]), 80'({8'hB0 + 8'(w / 4), 8'(w % 4)}));

    // Asynchronous reset in the middle of SEND.
    push_en   = 1'b1;
    push_data = 64'hFEDC_BA98_7654_3210;
    @(posedge rd_clk); #1;
    push_en = 1'b0;
    for (int c = 0; c < 20 && !word_valid; c++) begin
      @(posedge rd_clk); #1;
    end
    check("rst_reach_send", 80'(word_valid), 80'd1);
    @(posedge rd_clk); #1;
    not_reset = 1'b0;
    #2;
    $display("reset mid-send: valid=%b ofs=%0d data=%h lines=%0d", word_valid, word_ofs, word_data, lines_done);
    check("rst_async_outputs", 80'({fifo_read, word_valid, word_last, busy, word_ofs, lines_done, word_data}), 80'd0);
    @(posedge rd_clk); #1;
    @(posedge rd_clk); #1;
    not_reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge rd_clk);
      check($sformatf("rst_idle%0d", c), 80'({fifo_read, busy, word_valid}), 80'd0);
      @(posedge rd_clk); #1;
    end

    // Counter wrap: 257 lines after reset.
    h0 = hs_q.size();
    r0 = rd_q.size();
    word_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      push_en   = 1'b1;
      push_data = {4{16'(i)}};
      @(posedge rd_clk); #1;
    end
    push_en = 1'b0;
    for (int c = 0; c < 2500 && (busy || !fifo_empty); c++) begin
      @(posedge rd_clk); #1;
    end
    $display("wrap: reads=%0d words=%0d lines=%0d", rd_q.size() - r0, hs_q.size() - h0, lines_done);
    check("wrap_idle", 80'({busy, fifo_empty}), 80'b01);
    check("wrap_reads", 80'(rd_q.size() - r0), 80'd257);
    check("wrap_words", 80'(hs_q.size() - h0), 80'd1028);
    check("wrap_lines_done", 80'(lines_done), 80'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
